// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer bundle for uart_rx_cfg: received word, status flags and read strobe.
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
  parameter int unsigned NB_DATA = 8
);
  logic               i_rd;
  logic [NB_DATA-1:0] o_dout;
  logic               o_rx_done;
  logic               o_valid;
  logic               o_parity_err;
  logic               o_frame_err;
  logic               o_break;
  logic               o_overrun;

  modport master (
    input  i_rd,
    output o_dout, o_rx_done, o_valid, o_parity_err, o_frame_err, o_break, o_overrun
  );

  modport slave (
    output i_rd,
    input  o_dout, o_rx_done, o_valid, o_parity_err, o_frame_err, o_break, o_overrun
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled bit timing, runtime parity and stop-bit count,
// 3-sample majority vote, error/break flags and a valid/read handshake with overrun.
module uart_rx_cfg #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned N_TICKS     = 16,
  parameter int unsigned NB_TICK_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx,
  input  logic              i_tick,
  input  logic [1:0]        i_parity,
  input  logic              i_stop2,
  uart_rx_cfg_if.master     io_bus
);
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [NB_TICK_CNT-1:0] S_HALF = NB_TICK_CNT'(N_TICKS / 2 - 1);
  localparam logic [NB_TICK_CNT-1:0] S_SMP0 = NB_TICK_CNT'(N_TICKS - 3);
  localparam logic [NB_TICK_CNT-1:0] S_SMP1 = NB_TICK_CNT'(N_TICKS - 2);
  localparam logic [NB_TICK_CNT-1:0] S_LAST = NB_TICK_CNT'(N_TICKS - 1);
  localparam logic [3:0]             N_LAST = 4'(NB_DATA - 1);

  state_e                 r_state;
  logic                   r_rx_meta, r_rxs, r_rx_prev;
  logic [NB_TICK_CNT-1:0] r_s;
  logic [3:0]             r_n;
  logic [1:0]             r_smp;
  logic [NB_DATA-1:0]     r_data;
  logic [1:0]             r_par_mode;
  logic                   r_stop2, r_par_bit, r_perr, r_ferr;
  logic [NB_DATA-1:0]     r_dout;
  logic                   r_rx_done, r_valid, r_parity_err, r_frame_err, r_break, r_overrun;

  logic w_bit, w_bit_end, w_par_en, w_perr, w_ferr_fin, w_commit;

  // Third sample is taken live on the bit's final tick.
  assign w_bit      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxs) | (r_smp[1] & r_rxs);
  assign w_bit_end  = i_tick && (r_s == S_LAST);
  assign w_par_en   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_perr     = ((^r_data) ^ w_bit) != (r_par_mode == 2'b10);
  assign w_ferr_fin = r_ferr | ~w_bit;
  assign w_commit   = (r_state == StStop) && w_bit_end && (r_n == (r_stop2 ? 4'd1 : 4'd0));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rx_meta    <= 1'b1;
      r_rxs        <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= StIdle;
      r_s          <= '0;
      r_n          <= '0;
      r_smp        <= '0;
      r_data       <= '0;
      r_par_mode   <= '0;
      r_stop2      <= 1'b0;
      r_par_bit    <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_dout       <= '0;
      r_rx_done    <= 1'b0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rxs     <= r_rx_meta;
      r_rx_prev <= r_rxs;
      r_rx_done <= w_commit;

      if ((r_state inside {StData, StParity, StStop}) && i_tick) begin
        if (r_s == S_SMP0) r_smp[0] <= r_rxs;
        if (r_s == S_SMP1) r_smp[1] <= r_rxs;
        r_s <= w_bit_end ? '0 : r_s + 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          // Edge, not level: a line parked low after a break cannot restart a frame.
          if (r_rx_prev && !r_rxs) begin
            r_state    <= StStart;
            r_s        <= '0;
            r_par_mode <= i_parity;
            r_stop2    <= i_stop2;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        StStart: begin
          if (i_tick) begin
            if (r_s == S_HALF) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= r_rxs ? StIdle : StData;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_data <= {w_bit, r_data[NB_DATA-1:1]};
            if (r_n == N_LAST) begin
              r_n     <= '0;
              r_state <= w_par_en ? StParity : StStop;
            end else begin
              r_n <= r_n + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_par_bit <= w_bit;
            r_perr    <= w_perr;
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_ferr <= w_ferr_fin;
            if (w_commit) begin
              r_dout       <= r_data;
              r_parity_err <= r_perr;
              r_frame_err  <= w_ferr_fin;
              r_break      <= (r_data == '0) && !r_par_bit && w_ferr_fin;
              r_state      <= StIdle;
            end else begin
              r_n <= r_n + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase

      // A commit beats a same-cycle read: data stays valid and no overrun is flagged.
      if (w_commit) begin
        r_valid   <= 1'b1;
        r_overrun <= io_bus.i_rd ? 1'b0 : (r_overrun | r_valid);
      end else if (io_bus.i_rd) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign io_bus.o_dout       = r_dout;
  assign io_bus.o_rx_done    = r_rx_done;
  assign io_bus.o_valid      = r_valid;
  assign io_bus.o_parity_err = r_parity_err;
  assign io_bus.o_frame_err  = r_frame_err;
  assign io_bus.o_break      = r_break;
  assign io_bus.o_overrun    = r_overrun;
endmodule
